// File: rtl/alu_ctrl.sv
// alu_ctrl: issue/sequencing front end for the combinational 8-bit alu.
// Accepts requests over valid/ready and drives the alu one byte per cycle.
// Results and flags are registered and returned over a valid/ready response.
// Two-pass carry chaining through flags_q gives 16-bit ("wide") operations.
// Optional feature macro: ALU_CTRL_PIPE_EN. When it is defined, a new request
// may be accepted in the same cycle the response handshakes, so there is no
// idle cycle between back-to-back transactions.
`timescale 1ns/1ps
module alu_ctrl #(
  parameter int CARRY_BIT = 0,
  parameter int ZERO_BIT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mode,
  input  logic [3:0]  req_op,
  input  logic        req_wide,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  output logic [7:0]  flags_q,
  output logic        alu_mode,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_result,
  input  logic [7:0]  alu_flags
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        wide_q, wide_d;
  logic [7:0]  a_hi_q, a_hi_d;
  logic [7:0]  b_hi_q, b_hi_d;
  logic [15:0] result_q, result_d;
  logic        err_q, err_d;
  logic [7:0]  flags_d;
  logic        alu_mode_q, alu_mode_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic        take;

  // Only ops that decompose into two chained byte passes can run wide.
  function automatic logic wide_supported(input logic mode, input logic [3:0] op);
    if (mode) return (op >= 4'd1) && (op <= 4'd4);
    return ((op >= 4'd1) && (op <= 4'd7)) || (op == 4'd12);
  endfunction

  // High-byte pass must absorb the low-byte carry/borrow: add->adc, sub->sbb.
  function automatic logic [3:0] hi_op(input logic mode, input logic [3:0] op);
    if (mode && (op == 4'd1)) return 4'd2;
    if (mode && (op == 4'd3)) return 4'd4;
    return op;
  endfunction

`ifdef ALU_CTRL_PIPE_EN
  assign req_ready = (state_q == S_IDLE) || ((state_q == S_RSP) && rsp_ready);
`else
  assign req_ready = (state_q == S_IDLE);
`endif

  assign take       = req_valid && req_ready;
  assign rsp_valid  = (state_q == S_RSP);
  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign alu_mode   = alu_mode_q;
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;

  // Next-state, byte sequencing and result/flag capture.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    wide_d     = wide_q;
    a_hi_d     = a_hi_q;
    b_hi_d     = b_hi_q;
    result_d   = result_q;
    err_d      = err_q;
    flags_d    = flags_q;
    alu_mode_d = alu_mode_q;
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;

    case (state_q)
      S_LO: begin
        flags_d = alu_flags;
        if (wide_q) begin
          result_d[7:0] = alu_result;
          alu_op_d      = hi_op(alu_mode_q, alu_op_q);
          alu_a_d       = a_hi_q;
          alu_b_d       = b_hi_q;
          state_d       = S_HI;
        end else begin
          result_d = {8'h00, alu_result};
          state_d  = S_RSP;
        end
      end
      S_HI: begin
        result_d[15:8]     = alu_result;
        flags_d            = alu_flags;
        // Carry out of the high byte is the carry of the whole 16-bit op.
        flags_d[CARRY_BIT] = alu_flags[CARRY_BIT];
        // Zero must cover both bytes; flags_q still holds the low-byte zero.
        flags_d[ZERO_BIT]  = flags_q[ZERO_BIT] & alu_flags[ZERO_BIT];
        state_d            = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    // A newly accepted request overrides the hold/return-to-idle choice above.
    if (take) begin
      wide_d = req_wide;
      a_hi_d = req_a[15:8];
      b_hi_d = req_b[15:8];
      if (req_wide && !wide_supported(req_mode, req_op)) begin
        err_d    = 1'b1;
        result_d = 16'h0000;
        state_d  = S_RSP;
      end else begin
        err_d      = 1'b0;
        result_d   = 16'h0000;
        alu_mode_d = req_mode;
        alu_op_d   = req_op;
        alu_a_d    = req_a[7:0];
        alu_b_d    = req_b[7:0];
        state_d    = S_LO;
      end
    end
  end

  // State, latches and registered outputs; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wide_q     <= 1'b0;
      a_hi_q     <= 8'h00;
      b_hi_q     <= 8'h00;
      result_q   <= 16'h0000;
      err_q      <= 1'b0;
      flags_q    <= 8'h00;
      alu_mode_q <= 1'b0;
      alu_op_q   <= 4'h0;
      alu_a_q    <= 8'h00;
      alu_b_q    <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      wide_q     <= wide_d;
      a_hi_q     <= a_hi_d;
      b_hi_q     <= b_hi_d;
      result_q   <= result_d;
      err_q      <= err_d;
      flags_q    <= flags_d;
      alu_mode_q <= alu_mode_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: self-checking bench for alu_ctrl. Contains a combinational
// 8-bit alu model wired to the alu_* ports and a 16-bit reference model of
// the whole transaction computed with plain arithmetic.
`timescale 1ns/1ps
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_mode = 1'b0;
  logic [3:0]  req_op = 4'h0;
  logic        req_wide = 1'b0;
  logic [15:0] req_a = 16'h0;
  logic [15:0] req_b = 16'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic [7:0]  flags_q;
  logic        alu_mode;
  logic [3:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_result;
  logic [7:0]  alu_flags;

  always #5 clk = ~clk;

  alu_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_op     (req_op),
    .req_wide   (req_wide),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .flags_q    (flags_q),
    .alu_mode   (alu_mode),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_flags  (alu_flags)
  );

  typedef struct packed {
    logic        err;
    logic [7:0]  flags;
    logic [15:0] res;
  } exp_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // The external 8-bit alu: flags = {sign, 5'b0, zero, carry}.
  function automatic logic [15:0] alu8(input logic mode, input logic [3:0] op,
                                       input logic [7:0] a, input logic [7:0] b,
                                       input logic cin);
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  r;
    logic        c;
    r = 8'h00;
    c = 1'b0;
    if (mode) begin
      case (op)
        4'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
        4'd2: begin s = {1'b0, a} + {1'b0, b} + {8'h00, cin}; r = s[7:0]; c = s[8]; end
        4'd3: begin r = a - b; c = (a < b); end
        4'd4: begin r = a - b - {7'h00, cin}; c = ({1'b0, a} < ({1'b0, b} + {8'h00, cin})); end
        4'd5: begin p = {8'h00, a} * {8'h00, b}; r = p[7:0]; c = |p[15:8]; end
        default: r = 8'h00;
      endcase
    end else begin
      case (op)
        4'd1:  r = a & b;
        4'd2:  r = a | b;
        4'd3:  r = a ^ b;
        4'd4:  r = ~a;
        4'd5:  r = ~(a & b);
        4'd6:  r = ~(a | b);
        4'd7:  r = ~(a ^ b);
        4'd12: r = b;
        default: r = a;
      endcase
    end
    return {r[7], 5'b00000, (r == 8'h00), c, r};
  endfunction

  assign {alu_flags, alu_result} = alu8(alu_mode, alu_op, alu_a, alu_b, flags_q[0]);

  // Whole-transaction reference: wide ops are computed directly on 16 bits.
  function automatic exp_t model(input logic mode, input logic [3:0] op, input logic wide,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [7:0] fl);
    exp_t        e;
    logic [16:0] s;
    logic [15:0] r;
    logic [15:0] n;
    logic        c;
    logic        ok;
    e = '0;
    if (!wide) begin
      n = alu8(mode, op, a[7:0], b[7:0], fl[0]);
      e.res   = {8'h00, n[7:0]};
      e.flags = n[15:8];
      return e;
    end
    ok = mode ? (op inside {4'd1, 4'd2, 4'd3, 4'd4})
              : (op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12});
    if (!ok) begin
      e.err   = 1'b1;
      e.res   = 16'h0000;
      e.flags = fl;
      return e;
    end
    r = 16'h0000;
    c = 1'b0;
    if (mode) begin
      case (op)
        4'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
        4'd2: begin s = {1'b0, a} + {1'b0, b} + {16'h0, fl[0]}; r = s[15:0]; c = s[16]; end
        4'd3: begin r = a - b; c = (a < b); end
        default: begin r = a - b - {15'h0, fl[0]}; c = ({1'b0, a} < ({1'b0, b} + {16'h0, fl[0]})); end
      endcase
    end else begin
      case (op)
        4'd1: r = a & b;
        4'd2: r = a | b;
        4'd3: r = a ^ b;
        4'd4: r = ~a;
        4'd5: r = ~(a & b);
        4'd6: r = ~(a | b);
        4'd7: r = ~(a ^ b);
        default: r = b;
      endcase
    end
    e.res   = r;
    e.flags = {r[15], 5'b00000, (r == 16'h0000), c};
    return e;
  endfunction

  exp_t        exp_v = '0;
  logic        exp_on = 1'b0;
  logic [7:0]  m_flags = 8'h00;
  logic [15:0] cap_res;
  logic        cap_err;
  logic [7:0]  cap_flags;
  logic [7:0]  probe_lo;
  logic        probe_hi_c;

  // Compare process: while a response is expected, every valid cycle must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_on && rsp_valid) begin
        check("rsp_result", {16'h0, rsp_result}, {16'h0, exp_v.res});
        check("rsp_err", {31'h0, rsp_err}, {31'h0, exp_v.err});
        check("flags_q", {24'h0, flags_q}, {24'h0, exp_v.flags});
      end else if (!exp_on) begin
        check("rsp_valid_idle", {31'h0, rsp_valid}, 32'h0);
      end
    end
  end

  task automatic do_txn(input logic mode, input logic [3:0] op, input logic wide,
                        input logic [15:0] a, input logic [15:0] b,
                        input int stall, input bit probe);
    int n;
    int lat;
    int want_lat;
    exp_v    = model(mode, op, wide, a, b, m_flags);
    exp_on   = 1'b1;
    want_lat = exp_v.err ? 1 : (wide ? 3 : 2);
    @(negedge clk);
    req_valid = 1'b1;
    req_mode  = mode;
    req_op    = op;
    req_wide  = wide;
    req_a     = a;
    req_b     = b;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_accept", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      if (probe && lat == 1) probe_lo = alu_result;
      if (probe && lat == 2) probe_hi_c = flags_q[0];
      @(negedge clk);
      lat++;
    end
    check("latency", lat, want_lat);
    cap_res   = rsp_result;
    cap_err   = rsp_err;
    cap_flags = flags_q;
    for (int i = 0; i < stall; i++) begin
      check("req_ready_in_rsp", {31'h0, req_ready}, 32'h0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", {31'h0, rsp_valid}, 32'h0);
    if (!exp_v.err) m_flags = exp_v.flags;
    exp_on = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset_req_ready", {31'h0, req_ready}, 32'h1);
    check("reset_flags", {24'h0, flags_q}, 32'h0);
    check("reset_result", {16'h0, rsp_result}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: narrow add, two-edge latency
    do_txn(1'b1, 4'd1, 1'b0, 16'h0005, 16'h0003, 0, 1'b0);
    check("t1_result", {16'h0, cap_res}, 32'h0008);
    check("t1_carry", {31'h0, cap_flags[0]}, 32'h0);

    // 2: wide add with carry out of the low byte
    do_txn(1'b1, 4'd1, 1'b1, 16'h00FF, 16'h0001, 0, 1'b1);
    check("t2_lo_result", {24'h0, probe_lo}, 32'h00);
    check("t2_lo_carry", {31'h0, probe_hi_c}, 32'h1);
    check("t2_result", {16'h0, cap_res}, 32'h0100);
    check("t2_carry", {31'h0, cap_flags[0]}, 32'h0);
    check("t2_zero", {31'h0, cap_flags[1]}, 32'h0);

    // 3: wide sub with borrow, wide AND, narrow sub leaving carry/sign set
    do_txn(1'b1, 4'd3, 1'b1, 16'h0100, 16'h0001, 0, 1'b0);
    check("t3_sub_result", {16'h0, cap_res}, 32'h00FF);
    do_txn(1'b0, 4'd1, 1'b1, 16'h0F0F, 16'hFF00, 0, 1'b0);
    check("t3_and_result", {16'h0, cap_res}, 32'h0F00);
    check("t3_and_zero", {31'h0, cap_flags[1]}, 32'h0);
    do_txn(1'b1, 4'd3, 1'b0, 16'h0000, 16'h0001, 0, 1'b0);
    check("t3_nsub_flags", {24'h0, cap_flags}, 32'h81);

    // 4: unsupported wide op
    do_txn(1'b1, 4'd5, 1'b1, 16'h0004, 16'h0003, 0, 1'b0);
    check("t4_err", {31'h0, cap_err}, 32'h1);
    check("t4_result", {16'h0, cap_res}, 32'h0000);
    check("t4_flags_kept", {24'h0, cap_flags}, 32'h81);

    // 5: response stalled five cycles; narrow adc chains on the held carry
    do_txn(1'b1, 4'd2, 1'b0, 16'h0010, 16'h0020, 5, 1'b0);
    check("t5_adc_result", {16'h0, cap_res}, 32'h0031);

    // 6: reset during the high-byte pass
    @(negedge clk);
    req_valid = 1'b1; req_mode = 1'b1; req_op = 4'd1; req_wide = 1'b1;
    req_a = 16'h1234; req_b = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("t6_in_hi_op", {28'h0, alu_op}, 32'h2);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("t6_result", {16'h0, rsp_result}, 32'h0);
    check("t6_err", {31'h0, rsp_err}, 32'h0);
    check("t6_flags", {24'h0, flags_q}, 32'h0);
    check("t6_alu_out", {15'h0, alu_mode, alu_op, alu_a, alu_b}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_flags = 8'h00;
    check("t6_req_ready", {31'h0, req_ready}, 32'h1);
    repeat (4) @(negedge clk);

    // Randomized traffic against the reference model
    for (int t = 0; t < 80; t++) begin
      do_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
